// File: rtl/jedro_1_ifu_if.sv
// Fetch-side bus of the jedro_1 IFU: instruction RAM port, redirect input from execute
// and the valid/ready instruction stream towards the decoder.
interface jedro_1_ifu_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] iram_addr_o;
    logic [DATA_WIDTH-1:0] iram_rdata_i;
    logic                  jmp_instr_i;
    logic [ADDR_WIDTH-1:0] jmp_address_i;
    logic                  ready_i;
    logic                  valid_o;
    logic [DATA_WIDTH-1:0] instr_o;
    logic [ADDR_WIDTH-1:0] instr_addr_o;

    modport master (
        output iram_addr_o, valid_o, instr_o, instr_addr_o,
        input  iram_rdata_i, jmp_instr_i, jmp_address_i, ready_i
    );

    modport slave (
        input  iram_addr_o, valid_o, instr_o, instr_addr_o,
        output iram_rdata_i, jmp_instr_i, jmp_address_i, ready_i
    );
endinterface

// File: rtl/jedro_1_ifu.sv
// jedro_1 instruction fetch unit: credit-based prefetch from a 1-cycle synchronous RAM into a small FIFO.
// Optional JEDRO_1_IFU_MISALIGN_EXC_EN: flag misaligned redirect targets and halt fetching instead of aligning.
module jedro_1_ifu #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = '0,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                clk_i,
    input  logic                rstn_i,
`ifdef JEDRO_1_IFU_MISALIGN_EXC_EN
    output logic                jmp_misaligned_o,
`endif
    jedro_1_ifu_if.master       bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  inflight;
    logic [CW-1:0]         count;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];

    logic                  pop;
    logic                  push;
    logic                  issue;
    logic                  fetch_hold;
    logic                  jmp_misaligned;
    logic [CW:0]           occupancy;
    logic [ADDR_WIDTH-1:0] jmp_target;

    assign jmp_target = bus.jmp_address_i & ~ADDR_WIDTH'(3);

`ifdef JEDRO_1_IFU_MISALIGN_EXC_EN
    assign jmp_misaligned = bus.jmp_instr_i & (bus.jmp_address_i[1:0] != 2'b00);

    // A misaligned target parks the fetcher until execute sends a fresh redirect.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            fetch_hold       <= 1'b0;
            jmp_misaligned_o <= 1'b0;
        end else begin
            jmp_misaligned_o <= jmp_misaligned;
            if (bus.jmp_instr_i)
                fetch_hold <= jmp_misaligned;
        end
    end
`else
    assign jmp_misaligned = 1'b0;
    assign fetch_hold     = 1'b0;
`endif

    assign bus.valid_o      = (count != '0);
    assign bus.instr_o      = fifo_data[rd_ptr];
    assign bus.instr_addr_o = fifo_addr[rd_ptr];
    assign bus.iram_addr_o  = fetch_pc;

    assign pop  = bus.valid_o & bus.ready_i;
    assign push = inflight;

    // A new fetch is only issued when its word is guaranteed a FIFO slot on arrival.
    assign occupancy = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    assign issue     = !fetch_hold && (occupancy < (CW+1)'(FIFO_DEPTH));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            fetch_pc <= BOOT_ADDR;
            req_addr <= '0;
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i] <= NOP;
                fifo_addr[i] <= '0;
            end
        end else if (bus.jmp_instr_i) begin
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            if (!jmp_misaligned)
                fetch_pc <= jmp_target;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
                req_addr <= fetch_pc;
            end
            if (push) begin
                fifo_data[wr_ptr] <= bus.iram_rdata_i;
                fifo_addr[wr_ptr] <= req_addr;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assert property (@(posedge clk_i) disable iff (!rstn_i)
        !(push && !pop && !bus.jmp_instr_i && (count == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_jedro_1_ifu.sv
// Scoreboard bench for jedro_1_ifu: directed phases push expected delivery addresses,
// a negedge monitor checks every accepted instruction against them.
module tb_jedro_1_ifu;
    logic clk;
    logic rstn;
    int   checks;
    int   errors;
    logic [31:0] expq [$];

`ifdef JEDRO_1_IFU_MISALIGN_EXC_EN
    logic jmp_misaligned;
`endif

    jedro_1_ifu_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    jedro_1_ifu #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .BOOT_ADDR (32'h0000_0000),
        .FIFO_DEPTH(2)
    ) dut (
        .clk_i           (clk),
        .rstn_i          (rstn),
`ifdef JEDRO_1_IFU_MISALIGN_EXC_EN
        .jmp_misaligned_o(jmp_misaligned),
`endif
        .bus             (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ram_word(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: ram_word = 32'h0040_0093;
            32'h0000_0004: ram_word = 32'h0010_8113;
            default:       ram_word = {addr[23:0], 8'h13};
        endcase
    endfunction

    // Synchronous-read instruction RAM with one cycle of latency.
    always @(posedge clk) bus.iram_rdata_i <= ram_word(bus.iram_addr_o);

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rdy, input logic jmp, input logic [31:0] jaddr);
        bus.ready_i       = rdy;
        bus.jmp_instr_i   = jmp;
        bus.jmp_address_i = jaddr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepted instructions are compared in order against the scoreboard.
    always @(negedge clk) begin
        if (rstn && bus.valid_o && bus.ready_i && !bus.jmp_instr_i) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_delivery: got addr %h, expected none", bus.instr_addr_o);
            end else begin
                logic [31:0] exp_addr;
                exp_addr = expq.pop_front();
                checkOutput("deliver_addr", bus.instr_addr_o, exp_addr);
                checkOutput("deliver_instr", bus.instr_o, ram_word(exp_addr));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        rstn   = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h0);

        // Reset values and boot fetch sequence
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_valid", 32'(bus.valid_o), 32'h0);
        checkOutput("rst_iram_addr", bus.iram_addr_o, 32'h0);
        checkOutput("rst_instr", bus.instr_o, 32'h0000_0013);
        checkOutput("rst_instr_addr", bus.instr_addr_o, 32'h0);
`ifdef JEDRO_1_IFU_MISALIGN_EXC_EN
        checkOutput("rst_misaligned", 32'(jmp_misaligned), 32'h0);
`endif
        expq.push_back(32'h0);
        expq.push_back(32'h4);
        #2 rstn = 1'b1;
        tick();
        checkOutput("e1_valid", 32'(bus.valid_o), 32'h0);
        checkOutput("e1_iram_addr", bus.iram_addr_o, 32'h4);
        tick();
        checkOutput("e2_valid", 32'(bus.valid_o), 32'h1);
        checkOutput("e2_instr_addr", bus.instr_addr_o, 32'h0);
        checkOutput("e2_instr", bus.instr_o, 32'h0040_0093);
        tick();
        checkOutput("e3_instr_addr", bus.instr_addr_o, 32'h4);
        checkOutput("e3_instr", bus.instr_o, 32'h0010_8113);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0);

        // Decoder stall: head stable, fetcher stops once credits are used up
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("stall_valid", 32'(bus.valid_o), 32'h1);
            checkOutput("stall_instr_addr", bus.instr_addr_o, 32'h8);
            checkOutput("stall_iram_addr", bus.iram_addr_o, 32'h10);
        end
        expq.push_back(32'h8);
        expq.push_back(32'hC);
        expq.push_back(32'h10);
        applyStimulus(1'b1, 1'b0, 32'h0);
        repeat (3) tick();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("stall_drain", 32'(expq.size()), 32'h0);

        // Asynchronous reset in the middle of the stream
        checkOutput("pre_reset_valid", 32'(bus.valid_o), 32'h1);
        #3 rstn = 1'b0;
        #1;
        checkOutput("midrst_valid", 32'(bus.valid_o), 32'h0);
        checkOutput("midrst_iram_addr", bus.iram_addr_o, 32'h0);
        checkOutput("midrst_instr_addr", bus.instr_addr_o, 32'h0);
        checkOutput("midrst_instr", bus.instr_o, 32'h0000_0013);
        tick();
        #2 rstn = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h0);
        expq.push_back(32'h0);
        expq.push_back(32'h4);
        repeat (4) tick();
        checkOutput("pre_jmp_head", bus.instr_addr_o, 32'h8);

        // Redirect drops the accepted-looking head and bubbles two cycles
        applyStimulus(1'b1, 1'b1, 32'h40);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0);
        expq.push_back(32'h40);
        expq.push_back(32'h44);
        checkOutput("jmp_j0_valid", 32'(bus.valid_o), 32'h0);
        tick();
        checkOutput("jmp_j1_valid", 32'(bus.valid_o), 32'h0);
        tick();
        checkOutput("jmp_j2_valid", 32'(bus.valid_o), 32'h1);
        checkOutput("jmp_j2_instr_addr", bus.instr_addr_o, 32'h40);
        repeat (2) tick();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("jmp_drain", 32'(expq.size()), 32'h0);

        // Back-to-back redirects: only the final target is fetched
        applyStimulus(1'b1, 1'b1, 32'h40);
        tick();
        applyStimulus(1'b1, 1'b1, 32'h80);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0);
        expq.push_back(32'h80);
        expq.push_back(32'h84);
        expq.push_back(32'h88);
        checkOutput("b2b_valid0", 32'(bus.valid_o), 32'h0);
        checkOutput("b2b_iram_addr", bus.iram_addr_o, 32'h80);
        tick();
        checkOutput("b2b_valid1", 32'(bus.valid_o), 32'h0);
        tick();
        checkOutput("b2b_valid2", 32'(bus.valid_o), 32'h1);
        checkOutput("b2b_instr_addr", bus.instr_addr_o, 32'h80);
        repeat (3) tick();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("b2b_drain", 32'(expq.size()), 32'h0);

        // Misaligned redirect target
        applyStimulus(1'b1, 1'b1, 32'h42);
        tick();
`ifdef JEDRO_1_IFU_MISALIGN_EXC_EN
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("mis_pulse", 32'(jmp_misaligned), 32'h1);
        checkOutput("mis_valid0", 32'(bus.valid_o), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("mis_pulse_off", 32'(jmp_misaligned), 32'h0);
            checkOutput("mis_hold_valid", 32'(bus.valid_o), 32'h0);
        end
        applyStimulus(1'b1, 1'b1, 32'h40);
        tick();
`endif
        applyStimulus(1'b1, 1'b0, 32'h0);
        expq.push_back(32'h40);
        expq.push_back(32'h44);
        checkOutput("align_valid0", 32'(bus.valid_o), 32'h0);
        checkOutput("align_iram_addr", bus.iram_addr_o, 32'h40);
        tick();
        tick();
        checkOutput("align_valid2", 32'(bus.valid_o), 32'h1);
        checkOutput("align_instr_addr", bus.instr_addr_o, 32'h40);
        repeat (2) tick();
        applyStimulus(1'b0, 1'b0, 32'h0);
        repeat (2) tick();

        checkOutput("final_queue", 32'(expq.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
